health_alarm_sequencer: RTL
===========================

HEALTH_ALARM_SEQUENCER -- requirements
Module: health_alarm_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive high samples needed to confirm a condition; legal range 1..15.
REQ-002 Parameter GLYCEMIC_LIMIT, default 10: glycemic condition is true when glycemicIndex >= GLYCEMIC_LIMIT.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 presureAbnormality  input  1  pressure detector flag (level).
REQ-007 bloodAbnormality  input  1  blood detector flag (level).
REQ-008 fallDetected  input  1  fall detector flag (level).
REQ-009 glycemicIndex  input  4  glycemic index from the detector stage.
REQ-010 temperatureAbnormality  input  1  temperature detector flag (level).
REQ-011 alarmValid  output  1  an alarm is presented on alarmCode.
REQ-012 alarmReady  input  1  consumer accepts the presented alarm.
REQ-013 alarmCode  output  3  1=fall, 2=pressure, 3=blood, 4=temperature, 5=glycemic, 0=none.
REQ-014 pendingMask  output  5  latched unserviced conditions; bit order {glycemic,temp,blood,pressure,fall}.
REQ-015 alarmCount  output  8  accepted-alarm counter.

Function
REQ-016 All inputs SHALL be sampled on rising clk; no combinational path SHALL exist from any input to any output.
REQ-017 Each of the 5 sources SHALL have a 4-bit debounce counter that increments while its condition is high, saturates at DEBOUNCE_CYCLES, and clears to 0 on any low sample.
REQ-018 A source SHALL be confirmed only on the edge where its counter reaches DEBOUNCE_CYCLES; while it stays high and saturated, no further confirmation SHALL occur, so it must go low before it can re-trigger.
REQ-019 Confirmation SHALL set the source's pendingMask bit on that same edge; a bit that is already set SHALL remain set, with no duplicate queuing.
REQ-020 FSM states: IDLE, PRESENT.
REQ-021 IDLE: if pendingMask != 0, the FSM SHALL select the highest-priority set bit (fall > pressure > blood > temperature > glycemic), load alarmCode, and go to PRESENT; otherwise it SHALL stay in IDLE with alarmCode = 0.
REQ-022 PRESENT: alarmValid = 1 and alarmCode SHALL be held stable until accepted.
REQ-023 Acceptance occurs on an edge where alarmValid and alarmReady are both high; on that edge the selected pendingMask bit SHALL be cleared, alarmCount SHALL increment, and the FSM SHALL return to IDLE.
REQ-024 alarmValid SHALL be low for at least one cycle between consecutive alarms; minimum throughput is one alarm per 2 cycles.
REQ-025 A higher-priority confirmation during PRESENT SHALL NOT pre-empt the presented alarm; it is served on the next IDLE.
REQ-026 If the same source confirms on the edge its bit is cleared by acceptance, set SHALL win and the bit SHALL remain 1.
REQ-027 alarmReady while in IDLE SHALL be ignored.
REQ-028 alarmCount SHALL saturate at 255 and not wrap.
REQ-029 Latency: for a source high from edge k, its pending bit SHALL be set at edge k+DEBOUNCE_CYCLES-1, and alarmValid SHALL rise one edge later if the FSM is in IDLE.

Reset
REQ-030 resetN low SHALL immediately force IDLE, all debounce counters = 0, pendingMask = 0, alarmValid = 0, alarmCode = 0, and alarmCount = 0, independent of clk.
REQ-031 Reset asserted mid-PRESENT SHALL drop the alarm without counting it; after release, conditions SHALL be re-debounced from 0.

Verification
REQ-032 fallDetected high for 3 cycles then low (default parameters) -> pendingMask stays 0 and alarmValid never rises.
REQ-033 presureAbnormality held high, alarmReady = 1 -> pendingMask = 00010 after 4 samples; alarmValid = 1 with alarmCode = 2 for one cycle; alarmCount = 1; no second alarm while the input stays high.
REQ-034 bloodAbnormality and temperatureAbnormality confirmed on the same edge, alarmReady = 1 -> codes 3 then 4, with alarmValid low one cycle between them; alarmCount = 2.
REQ-035 glycemicIndex = 9 held for 10 cycles -> no alarm; glycemicIndex = 10 held -> alarmCode = 5.
REQ-036 alarmReady = 0 with the glycemic alarm presented, then fall confirms -> alarmCode stays 5 with pendingMask = 10001; alarmReady = 1 -> code 5 accepted, then code 1.
REQ-037 resetN pulsed low during PRESENT -> all outputs 0 asynchronously, alarmCount = 0; an input still held high re-alarms 4 samples after release.

Source files
------------

// File: rtl/health_alarm_sequencer_if.sv
// Alarm presentation handshake between the sequencer (master) and its consumer (slave).
interface health_alarm_sequencer_if;
    logic       alarmValid;
    logic       alarmReady;
    logic [2:0] alarmCode;

    modport master (output alarmValid, output alarmCode, input alarmReady);
    modport slave  (input alarmValid, input alarmCode, output alarmReady);
endinterface

// File: rtl/health_alarm_sequencer.sv
// Debounces five health detector flags, latches confirmed conditions and presents them
// one at a time, by fixed priority, over a valid/ready alarm handshake.
module health_alarm_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLYCEMIC_LIMIT  = 10
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            presureAbnormality,
    input  logic                            bloodAbnormality,
    input  logic                            fallDetected,
    input  logic [3:0]                      glycemicIndex,
    input  logic                            temperatureAbnormality,
    health_alarm_sequencer_if.master        bus,
    output logic [4:0]                      pendingMask,
    output logic [7:0]                      alarmCount
);

    localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

    logic [4:0] w_cond;
    logic [4:0] w_confirm;
    logic [4:0] w_clear;
    logic [4:0] w_pick;
    logic [2:0] w_pick_code;

    logic [3:0] r_deb [5];
    state_t     r_state;
    logic [4:0] r_pend;
    logic [4:0] r_sel;
    logic       r_valid;
    logic [2:0] r_code;
    logic [7:0] r_count;

    // Bit order matches pendingMask: {glycemic, temp, blood, pressure, fall}.
    assign w_cond = {int'(glycemicIndex) >= GLYCEMIC_LIMIT, temperatureAbnormality,
                     bloodAbnormality, presureAbnormality, fallDetected};

    // A source confirms only on the edge its counter steps from DEBOUNCE_CYCLES-1 to the limit.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        w_confirm = '0;
        for (int i = 0; i < 5; i++) begin
            w_confirm[i] = w_cond[i] && (r_deb[i] == DEB_LAST);
        end
    end

    // Lowest index wins: fall > pressure > blood > temperature > glycemic.
    always_comb begin
        w_pick      = '0;
        w_pick_code = '0;
        for (int i = 4; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_pick      = 5'b00001 << i;
                w_pick_code = 3'(i + 1);
            end
        end
    end

    assign w_clear = (r_state == ST_PRESENT && bus.alarmReady) ? r_sel : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: every counter is reset so conditions re-debounce from zero after reset.
            for (int i = 0; i < 5; i++) r_deb[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!w_cond[i])              r_deb[i] <= '0;
                else if (r_deb[i] != DEB_MAX) r_deb[i] <= r_deb[i] + 4'd1;
            end
        end
    end

    // A confirmation coinciding with acceptance of the same source keeps its bit set.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_code  <= '0;
            r_count <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clear) | w_confirm;
            case (r_state)
                ST_IDLE: begin
                    if (r_pend != '0) begin
                        r_sel   <= w_pick;
                        r_code  <= w_pick_code;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.alarmReady) begin
                        r_valid <= 1'b0;
                        r_code  <= '0;
                        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.alarmValid = r_valid;
    assign bus.alarmCode  = r_code;
    assign pendingMask    = r_pend;
    assign alarmCount     = r_count;

endmodule
